// File: rtl/delay_tap_ctrl_if.sv
// Request/status interface for the delay tap controller.
// The requester (master) offers a target tap or a load request and watches
// the tracked tap, busy and completion flags; the controller is the slave.
interface delay_tap_ctrl_if #(
    parameter int TAP_W = 7
);
    logic             req_valid;
    logic             req_ready;
    logic [TAP_W-1:0] req_tap;
    logic             req_load;
    logic [TAP_W-1:0] cur_tap;
    logic             busy;
    logic             done;
    logic             clamped;

    modport master (
        output req_valid, req_tap, req_load,
        input  req_ready, cur_tap, busy, done, clamped
    );

    modport slave (
        input  req_valid, req_tap, req_load,
        output req_ready, cur_tap, busy, done, clamped
    );
endinterface

// File: rtl/delay_tap_ctrl.sv
// Delay tap controller: walks an incremental delay element (move/dir/loadn
// strobes) from its tracked current tap to a requested target tap, one
// pulse per tap, or reloads it to LOAD_TAP through the active-low load.
// Every output except req_ready is registered from the next-state values.
module delay_tap_ctrl #(
    parameter int TAP_W     = 7,
    parameter int MAX_TAP   = 127,
    parameter int LOAD_TAP  = 0,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    delay_tap_ctrl_if.slave        req_if,
    output logic                   dly_loadn,
    output logic                   dly_move,
    output logic                   dly_dir
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SETUP   = 3'd2,
        MOVE_HI = 3'd3,
        MOVE_LO = 3'd4,
        DONE    = 3'd5
    } state_t;

    // The phase counter only ever has to reach the longer of the two timings.
    localparam int CNT_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [TAP_W-1:0] MAX_T      = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] LOAD_T     = TAP_W'(LOAD_TAP);

    state_t           state,      state_nxt;
    logic [CNT_W-1:0] cnt,        cnt_nxt;
    logic [TAP_W-1:0] target,     target_nxt;
    logic             clamp_flag, clamp_flag_nxt;
    logic [TAP_W-1:0] cur_tap,    cur_tap_nxt;
    logic             dir_q,      dir_nxt;
    logic             move_q,     move_nxt;
    logic             loadn_q,    loadn_nxt;
    logic             busy_q,     busy_nxt;
    logic             done_q,     done_nxt;
    logic             clamped_q,  clamped_nxt;

    assign req_if.req_ready = (state == IDLE);
    assign req_if.cur_tap   = cur_tap;
    assign req_if.busy      = busy_q;
    assign req_if.done      = done_q;
    assign req_if.clamped   = clamped_q;
    assign dly_loadn        = loadn_q;
    assign dly_move         = move_q;
    assign dly_dir          = dir_q;

    // State register; reset drops any request in flight back to IDLE.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers; reset also holds the element in load so
    // the tracked tap and the physical element agree again afterwards.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt        <= '0;
            target     <= '0;
            clamp_flag <= 1'b0;
            cur_tap    <= LOAD_T;
            dir_q      <= 1'b0;
            move_q     <= 1'b0;
            loadn_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clamped_q  <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            target     <= target_nxt;
            clamp_flag <= clamp_flag_nxt;
            cur_tap    <= cur_tap_nxt;
            dir_q      <= dir_nxt;
            move_q     <= move_nxt;
            loadn_q    <= loadn_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            clamped_q  <= clamped_nxt;
        end
    end

    // Next-state logic; outputs are derived from the next state so they line
    // up with the state they describe once registered.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        target_nxt     = target;
        clamp_flag_nxt = clamp_flag;
        cur_tap_nxt    = cur_tap;
        dir_nxt        = dir_q;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (req_if.req_valid) begin
                    if (req_if.req_load) begin
                        target_nxt     = LOAD_T;
                        clamp_flag_nxt = 1'b0;
                        state_nxt      = LOAD;
                    end else begin
                        clamp_flag_nxt = (req_if.req_tap > MAX_T);
                        target_nxt     = clamp_flag_nxt ? MAX_T : req_if.req_tap;
                        if (target_nxt == cur_tap) begin
                            state_nxt = DONE;
                        end else begin
                            dir_nxt   = (target_nxt < cur_tap);
                            state_nxt = SETUP;
                        end
                    end
                end
            end
            LOAD: begin
                if (cnt == PULSE_LAST) begin
                    cnt_nxt     = '0;
                    cur_tap_nxt = LOAD_T;
                    state_nxt   = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = MOVE_HI;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            MOVE_HI: begin
                if (cnt == PULSE_LAST) begin
                    cnt_nxt = '0;
                    if (dir_q && (cur_tap != '0)) begin
                        cur_tap_nxt = cur_tap - 1'b1;
                    end else if (!dir_q && (cur_tap != MAX_T)) begin
                        cur_tap_nxt = cur_tap + 1'b1;
                    end
                    state_nxt = MOVE_LO;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            MOVE_LO: begin
                if (cnt == PULSE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = (cur_tap == target) ? DONE : MOVE_HI;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt    = (state_nxt != IDLE);
        done_nxt    = (state_nxt == DONE);
        clamped_nxt = (state_nxt == DONE) && clamp_flag_nxt;
        move_nxt    = (state_nxt == MOVE_HI);
        loadn_nxt   = (state_nxt != LOAD);
    end

endmodule

// File: doc/delay_tap_ctrl.md
DELAY_TAP_CTRL -- requirements
Module: delay_tap_ctrl

Interface
REQ-001 Parameter TAP_W, default 7, is the width of the tap counter and tap request.
REQ-002 Parameter MAX_TAP, default 127, is the highest legal tap value.
REQ-003 Parameter LOAD_TAP, default 0, is the tap value the delay element holds after a LOADN pulse.
REQ-004 Parameter SETUP_CYC, default 2, gives the cycles for which dly_dir is stable before the first move pulse; legal range is 1 or more.
REQ-005 Parameter PULSE_CYC, default 2, gives the high and low width, in cycles, of each move or load pulse; legal range is 1 or more.
REQ-006 sys_clk  in  1  is the single clock; all logic is rising-edge.
REQ-007 sys_rst  in  1  is a synchronous, active-high reset.
REQ-008 req_valid  in  1  signals that a tap request is offered.
REQ-009 req_ready  out  1  signals that the controller accepts a request this cycle.
REQ-010 req_tap  in  TAP_W  is the requested target tap.
REQ-011 req_load  in  1  requests a LOADN reset of the element instead of a move; req_tap is ignored when it is set.
REQ-012 cur_tap  out  TAP_W  is the tracked current tap of the delay element.
REQ-013 busy  out  1  signals that a request is in progress.
REQ-014 done  out  1  is a one-cycle pulse at request completion.
REQ-015 clamped  out  1  is valid with done and is high if req_tap exceeded MAX_TAP.
REQ-016 dly_loadn  out  1  is the active-low load to the delay element.
REQ-017 dly_move  out  1  is the move strobe; each high-then-low pulse moves the element by one tap.
REQ-018 dly_dir  out  1  is the move direction: 0 increments the tap, 1 decrements it.

Function
REQ-019 All outputs SHALL be registered, except req_ready, which equals (state==IDLE).
REQ-020 The FSM states SHALL be IDLE, LOAD, SETUP, MOVE_HI, MOVE_LO and DONE; busy SHALL be 1 in every state except IDLE.
REQ-021 In IDLE with req_valid=1, the handshake SHALL capture target = min(req_tap, MAX_TAP) and set the clamp flag to (req_tap > MAX_TAP).
REQ-022 From IDLE on handshake, the next state SHALL be: LOAD if req_load; otherwise DONE if target==cur_tap; otherwise SETUP, with dly_dir set to (target < cur_tap).
REQ-023 In LOAD, dly_loadn SHALL be 0 for PULSE_CYC cycles, cur_tap SHALL be set to LOAD_TAP on exit, and the next state SHALL be DONE.
REQ-024 In SETUP, dly_move SHALL be 0 and dly_dir held for SETUP_CYC cycles, then the state SHALL go to MOVE_HI.
REQ-025 In MOVE_HI, dly_move SHALL be 1 for PULSE_CYC cycles; on exit cur_tap SHALL step by +1 (dir=0) or -1 (dir=1), and the next state SHALL be MOVE_LO.
REQ-026 In MOVE_LO, dly_move SHALL be 0 for PULSE_CYC cycles, then the state SHALL go to DONE if cur_tap==target, else back to MOVE_HI with no repeated SETUP.
REQ-027 In DONE, done SHALL be 1 for exactly one cycle with clamped valid, and the next state SHALL be IDLE.
REQ-028 Latency from the handshake cycle to the done cycle SHALL be 1 + SETUP_CYC + 2*PULSE_CYC*N cycles for N = |target - cur_tap| > 0, 1 cycle for N=0, and 1+PULSE_CYC cycles for a load.
REQ-029 cur_tap SHALL never leave the range 0..MAX_TAP; no wrap-around is permitted.
REQ-030 dly_dir SHALL change only on the handshake cycle and SHALL be held otherwise, including in IDLE.
REQ-031 dly_loadn SHALL be 1 outside LOAD and outside reset.
REQ-032 A request arriving while busy SHALL NOT be accepted; the requester holds it, and no request is queued.

Reset
REQ-033 While sys_rst=1: state=IDLE, cur_tap=LOAD_TAP, dly_loadn=0, dly_move=0, dly_dir=0, busy=0, done=0 and clamped=0.
REQ-034 dly_loadn SHALL return to 1 on the first clock edge after sys_rst deasserts.
REQ-035 A reset asserted mid-operation SHALL abort the request immediately, with no done pulse, and SHALL apply the REQ-033 values on the next edge.
REQ-036 A reset asserted mid-operation SHALL force dly_move low and resynchronise cur_tap through the loadn reset.

Verification
REQ-037 Defaults, cur_tap=0, request tap 3 -> dly_dir=0; three move pulses of 2 high and 2 low cycles; done at handshake+15; cur_tap=3; clamped=0.
REQ-038 cur_tap=3, request tap 1 -> dly_dir=1; two pulses; done at handshake+11; cur_tap=1.
REQ-039 Request tap 200 with MAX_TAP=127 from 125 -> two increment pulses; cur_tap=127; clamped=1 with done.
REQ-040 Request equal to cur_tap -> no dly_move activity; done at handshake+1.
REQ-041 req_load from tap 50 -> dly_loadn low for 2 cycles; done at handshake+3; cur_tap=0.
REQ-042 sys_rst during the second MOVE_HI -> next edge dly_move=0, cur_tap=0, busy=0, no done; req_valid held through busy is not accepted until IDLE.
